eth_tx_payload_buf: RTL
=======================

Name: eth_tx_payload_buf

Overview:
- Upstream payload buffer for the IP/UDP transmit stage (ip_protocol); single clock domain, mii_tx_clk.
- Accepts whole frames of payload bytes from the user/application side and stores them in a ring buffer.
- Per committed frame, pulses tx_go with data_len to the transmit stage, then serves payload as nibbles (low nibble first) on its fifo_rq requests.
- Frames that overflow the buffer are discarded atomically.

Parameters:
- ADDR_W, 11, byte-address width of the ring buffer (depth = 2**ADDR_W bytes).
- LEN_FIFO_DEPTH, 4, number of committed frame lengths queued (power of 2).
- IFG_CYC, 24, idle mii_tx_clk cycles between frame-done and the next tx_go.
- MIN_LEN, 18, minimum payload bytes; used only with TXBUF_PAD_EN.

Ports:
- mii_tx_clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe, one byte per cycle.
- wr_data  input  8  payload byte.
- wr_last  input  1  qualifies wr_en; marks the final byte of a frame.
- wr_full  output  1  ring buffer or length queue full.
- wr_drop  output  1  one-cycle pulse when a frame is discarded.
- tx_go  output  1  one-cycle frame start to the transmit stage.
- data_len  output  12  frame payload length in bytes; valid from tx_go until frame done.
- fifo_rq  input  1  nibble request from the transmit stage.
- fifo_da  output  4  current payload nibble.
- tx_busy  output  1  high from tx_go until the end of the IFG.

Behaviour:
- Reset: all pointers 0, length queue empty, state IDLE. tx_go=0, data_len=0, fifo_da=0, wr_full=0, wr_drop=0, tx_busy=0.
- Write side:
  - wr_ptr increments per accepted byte; frame_start holds the first byte address of the frame being loaded.
  - Byte counter is 12 bits.
  - On wr_en&wr_last: if the frame is not marked bad, push the length (byte count including the last byte) into the length queue and set frame_start=wr_ptr+1.
- Bad frame: the frame is marked bad if either of the following occurs:
  - wr_en is asserted while wr_full is high; or
  - the byte count would exceed 4095.
- Bad-frame handling:
  - Bad frames ignore all further bytes.
  - At wr_last, wr_ptr rewinds to frame_start and wr_drop pulses the next cycle.
  - A wr_last that arrives while wr_full is high still terminates the frame, which is dropped.
- wr_full: asserts when (wr_ptr+1)==rd_commit_ptr (byte space) or the length queue holds LEN_FIFO_DEPTH entries.
- Read FSM states IDLE -> GO -> SEND -> GAP -> IDLE:
  - IDLE: when the length queue is non-empty, pop the length into data_len and prefetch the first byte; go to GO.
  - GO: assert tx_go for one cycle and tx_busy=1. fifo_da = low nibble of byte 0, presented in the same cycle as tx_go.
  - SEND: each rising edge with fifo_rq=1 advances fifo_da one cycle later: low->high nibble, then high->next byte's low nibble.
    - The byte prefetch must hide RAM read latency, so back-to-back fifo_rq streams with no bubbles.
    - After 2*data_len requests, the frame is done: rd_commit_ptr=rd_ptr, fifo_da=0, and further fifo_rq are ignored. Go to GAP.
  - GAP: count IFG_CYC cycles, then drop tx_busy and return to IDLE.
- Address arithmetic wraps modulo 2**ADDR_W.
- Simultaneous events:
  - Write and read in the same cycle are legal.
  - A length pushed in the same cycle as an empty-queue pop is seen the next cycle.
  - A commit and the wr_full evaluation in the same cycle use the pre-commit rd_commit_ptr.
- fifo_rq outside SEND: ignored.
- Reset mid-frame: everything is cleared immediately; partial frames are lost.

Optional Feature:
- Macro: TXBUF_PAD_EN.
- Defined: if a popped length is < MIN_LEN, data_len=MIN_LEN. After the real bytes are exhausted, fifo_da outputs 0 for the remaining nibbles; the read pointer advances only over the real bytes.
- Undefined: data_len always equals the written length; no padding.

Test Plan:
- Write a 28-byte frame 0x00..0x1B, hold fifo_rq high -> one tx_go, data_len=28; fifo_da sequence 0,0,1,0,2,0,...,B,1 (56 nibbles); tx_busy falls 24 cycles after the last nibble.
- Two 4-byte frames written back-to-back -> second tx_go exactly IFG_CYC+2 cycles after the first frame done; data_len=4 each time; nibbles correct.
- ADDR_W=4, write a 20-byte frame -> wr_full high after 15 bytes; wr_drop pulses once; no tx_go. A following 8-byte frame transmits correctly.
- Pulse fifo_rq every third cycle on a 6-byte frame -> fifo_da holds between requests; exactly 12 advances; then fifo_da=0.
- Assert rst_n=0 mid-SEND -> all outputs return to reset values immediately; a subsequent 10-byte frame is sent cleanly.
- TXBUF_PAD_EN, 5-byte frame -> data_len=18; 10 real nibbles followed by 26 zero nibbles.

Source files
------------

// File: rtl/eth_tx_payload_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : eth_tx_payload_buf                                            |
// | Purpose  : Payload ring buffer in front of the IP/UDP transmit stage.    |
// |            Whole frames are written byte-wise, committed on wr_last and  |
// |            replayed as nibbles (low nibble first) on fifo_rq requests.   |
// |            Frames that overflow the ring or exceed 4095 bytes are        |
// |            discarded atomically by rewinding the write pointer.          |
// | Clock    : mii_tx_clk, single domain.                                    |
// | Reset    : rst_n, asynchronous, active-low.                              |
// | Ports    : wr_en/wr_data/wr_last - byte write side, wr_last marks end    |
// |            wr_full                 - ring or length queue full          |
// |            wr_drop                 - one-cycle pulse, frame discarded   |
// |            tx_go/data_len          - frame start pulse and its length   |
// |            fifo_rq/fifo_da         - nibble request / current nibble    |
// |            tx_busy                 - high from tx_go to end of the IFG  |
// | Config   : `define TXBUF_PAD_EN pads short frames to MIN_LEN bytes with |
// |            zero nibbles. Undefined: data_len is the written length.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module eth_tx_payload_buf #(
    parameter int ADDR_W         = 11,  // ring depth = 2**ADDR_W bytes
    parameter int LEN_FIFO_DEPTH = 4,   // committed lengths queued, power of 2, >= 2
    parameter int IFG_CYC        = 24,  // idle cycles after a frame, >= 1
    parameter int MIN_LEN        = 18   // pad target, used with TXBUF_PAD_EN
) (
    input  logic        mii_tx_clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_full,
    output logic        wr_drop,
    output logic        tx_go,
    output logic [11:0] data_len,
    input  logic        fifo_rq,
    output logic [3:0]  fifo_da,
    output logic        tx_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LQ_AW = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
    localparam int GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    localparam logic [LQ_AW:0]   LQ_FULL_CNT = (LQ_AW + 1)'(LEN_FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(IFG_CYC - 1);
    localparam logic [11:0]      MIN_LEN12   = 12'(MIN_LEN);
    localparam logic [11:0]      CNT_MAX     = 12'hFFF;

`ifdef TXBUF_PAD_EN
    localparam logic PAD_ON = 1'b1;
`else
    localparam logic PAD_ON = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GO   = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]  mem_q    [0:DEPTH-1];
    logic [11:0] lq_mem_q [0:LEN_FIFO_DEPTH-1];
    logic [7:0]  ram_q;

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] frame_start_q, frame_start_d;
    logic [11:0]       byte_cnt_q, byte_cnt_d;
    logic              bad_q, bad_d;
    logic              drop_q, drop_d;

    // ------------------------------------------------------------------
    // Length queue state
    // ------------------------------------------------------------------
    logic [LQ_AW-1:0] lq_wp_q, lq_rp_q;
    logic [LQ_AW:0]   lq_cnt_q, lq_cnt_d;

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [11:0]       data_len_q, data_len_d;
    logic [11:0]       real_len_q, real_len_d;
    logic [11:0]       fetch_left_q, fetch_left_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_commit_ptr_q, rd_commit_d;
    logic [12:0]       nib_cnt_q, nib_cnt_d;
    logic [7:0]        cur_q, cur_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_wr_ptr_inc;
    logic              w_lq_full;
    logic              w_lq_empty;
    logic              w_cnt_over;
    logic              w_reject;
    logic              w_mem_we;
    logic              w_lq_push;
    logic              w_lq_pop;
    logic              w_rd_en;
    logic              w_more;
    logic              w_last_nib;
    logic [11:0]       w_len_head;
    logic [11:0]       w_len_padded;
    logic [7:0]        w_show_byte;
    logic [3:0]        w_nib;
    logic              w_real_byte;

    assign w_wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
    assign w_lq_full    = (lq_cnt_q == LQ_FULL_CNT);
    assign w_lq_empty   = (lq_cnt_q == '0);

    // rd_commit_ptr only moves once a frame has been fully sent, so the
    // bytes of the frame in flight stay protected from the writer.
    assign wr_full = (w_wr_ptr_inc == rd_commit_ptr_q) || w_lq_full;

    // A byte is refused once the frame is bad, the ring is full, or the
    // 12-bit length would overflow; any refusal poisons the whole frame.
    assign w_cnt_over = (byte_cnt_q == CNT_MAX);
    assign w_reject   = bad_q | wr_full | w_cnt_over;
    assign w_mem_we   = wr_en & ~w_reject;
    assign w_lq_push  = wr_en & wr_last & ~w_reject;

    // ------------------------------------------------------------------
    // Write side next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        byte_cnt_d    = byte_cnt_q;
        bad_d         = bad_q;
        drop_d        = 1'b0;
        if (wr_en) begin
            if (wr_last) begin
                byte_cnt_d = '0;
                bad_d      = 1'b0;
                if (w_reject) begin
                    // Discard: forget every byte of this frame.
                    wr_ptr_d = frame_start_q;
                    drop_d   = 1'b1;
                end else begin
                    wr_ptr_d      = w_wr_ptr_inc;
                    frame_start_d = w_wr_ptr_inc;
                end
            end else if (w_reject) begin
                bad_d = 1'b1;
            end else begin
                wr_ptr_d   = w_wr_ptr_inc;
                byte_cnt_d = byte_cnt_q + 12'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Length queue occupancy
    // ------------------------------------------------------------------
    always_comb begin
        lq_cnt_d = lq_cnt_q;
        case ({w_lq_push, w_lq_pop})
            2'b10:   lq_cnt_d = lq_cnt_q + 1'b1;
            2'b01:   lq_cnt_d = lq_cnt_q - 1'b1;
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    assign w_len_head   = lq_mem_q[lq_rp_q];
    assign w_len_padded = (PAD_ON && (w_len_head < MIN_LEN12)) ? MIN_LEN12 : w_len_head;

    // ------------------------------------------------------------------
    // Read FSM
    //
    // Two byte stages hide the synchronous RAM latency: cur_q is the byte
    // on fifo_da, ram_q already holds the following byte. A byte needs at
    // least two requests, so the refill read always lands in time.
    // During GO the first byte is still in ram_q and is shown from there.
    // ------------------------------------------------------------------
    assign w_more     = (fetch_left_q != '0);
    assign w_last_nib = (nib_cnt_q == ({data_len_q, 1'b0} - 13'd1));

    always_comb begin
        state_d      = state_q;
        data_len_d   = data_len_q;
        real_len_d   = real_len_q;
        fetch_left_d = fetch_left_q;
        rd_ptr_d     = rd_ptr_q;
        rd_commit_d  = rd_commit_ptr_q;
        nib_cnt_d    = nib_cnt_q;
        cur_d        = cur_q;
        gap_cnt_d    = gap_cnt_q;
        w_rd_en      = 1'b0;
        w_lq_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_lq_empty) begin
                    w_lq_pop     = 1'b1;
                    data_len_d   = w_len_padded;
                    real_len_d   = w_len_head;
                    w_rd_en      = 1'b1;
                    rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
                    fetch_left_d = w_len_head - 12'd1;
                    nib_cnt_d    = '0;
                    state_d      = S_GO;
                end
            end
            S_GO: begin
                cur_d = ram_q;
                if (w_more) begin
                    w_rd_en      = 1'b1;
                    rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
                    fetch_left_d = fetch_left_q - 12'd1;
                end
                state_d = S_SEND;
            end
            S_SEND: begin
                if (fifo_rq) begin
                    if (w_last_nib) begin
                        // All real bytes were fetched earlier, so rd_ptr_q
                        // is already the start of the next frame.
                        rd_commit_d = rd_ptr_q;
                        gap_cnt_d   = '0;
                        state_d     = S_GAP;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 13'd1;
                        if (nib_cnt_q[0]) begin
                            cur_d = ram_q;
                            if (w_more) begin
                                w_rd_en      = 1'b1;
                                rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
                                fetch_left_d = fetch_left_q - 12'd1;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Nibble output; bytes past the real length read as zero (padding)
    // ------------------------------------------------------------------
    assign w_show_byte = (state_q == S_GO) ? ram_q : cur_q;
    assign w_nib       = nib_cnt_q[0] ? w_show_byte[7:4] : w_show_byte[3:0];
    assign w_real_byte = (nib_cnt_q[12:1] < real_len_q);

    always_comb begin
        fifo_da = 4'd0;
        if (((state_q == S_GO) || (state_q == S_SEND)) && w_real_byte) begin
            fifo_da = w_nib;
        end
    end

    assign tx_go    = (state_q == S_GO);
    assign tx_busy  = (state_q != S_IDLE);
    assign data_len = data_len_q;
    assign wr_drop  = drop_q;

    // ------------------------------------------------------------------
    // Storage arrays (no reset, RAM style)
    // ------------------------------------------------------------------
    always_ff @(posedge mii_tx_clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
        if (w_rd_en) begin
            ram_q <= mem_q[rd_ptr_q];
        end
        if (w_lq_push) begin
            lq_mem_q[lq_wp_q] <= byte_cnt_q + 12'd1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            frame_start_q   <= '0;
            byte_cnt_q      <= '0;
            bad_q           <= 1'b0;
            drop_q          <= 1'b0;
            lq_wp_q         <= '0;
            lq_rp_q         <= '0;
            lq_cnt_q        <= '0;
            state_q         <= S_IDLE;
            data_len_q      <= '0;
            real_len_q      <= '0;
            fetch_left_q    <= '0;
            rd_ptr_q        <= '0;
            rd_commit_ptr_q <= '0;
            nib_cnt_q       <= '0;
            cur_q           <= '0;
            gap_cnt_q       <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            frame_start_q   <= frame_start_d;
            byte_cnt_q      <= byte_cnt_d;
            bad_q           <= bad_d;
            drop_q          <= drop_d;
            lq_cnt_q        <= lq_cnt_d;
            if (w_lq_push) begin
                lq_wp_q <= lq_wp_q + 1'b1;
            end
            if (w_lq_pop) begin
                lq_rp_q <= lq_rp_q + 1'b1;
            end
            state_q         <= state_d;
            data_len_q      <= data_len_d;
            real_len_q      <= real_len_d;
            fetch_left_q    <= fetch_left_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_commit_ptr_q <= rd_commit_d;
            nib_cnt_q       <= nib_cnt_d;
            cur_q           <= cur_d;
            gap_cnt_q       <= gap_cnt_d;
        end
    end

endmodule

`default_nettype wire
